// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_param
// Brief    : Parametrised UART transmitter (start, DATA_BITS LSB-first,
//            optional parity, 1..2 stop bits) timed by oversample ticks.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic                 clk_en,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 busy,
   output logic                 tx_done,
   output logic                 tx
);

   localparam int c_TICK_W = $clog2(OVERSAMPLE);
   localparam int c_BIT_W  = $clog2(DATA_BITS + 1);
   localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
   localparam logic [c_BIT_W-1:0]  c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);
   localparam logic [c_BIT_W-1:0]  c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                r_state;
   logic [c_TICK_W-1:0]   r_tick;
   logic [c_BIT_W-1:0]    r_bit_cnt;
   logic [DATA_BITS-1:0]  r_shift;
   logic                  r_parity;
   logic                  r_tx;
   logic                  r_busy;
   logic                  r_done;

   assign tx_ready = (r_state == S_IDLE) && !reset;
   assign busy     = r_busy;
   assign tx_done  = r_done;
   assign tx       = r_tx;

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_tick    <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            // Acceptance ignores clk_en; the start bit begins on this edge.
            if (tx_valid) begin
               r_shift   <= tx_data;
               r_parity  <= (PARITY == 1) ? ~^tx_data : ^tx_data;
               r_tick    <= '0;
               r_bit_cnt <= '0;
               r_tx      <= 1'b0;
               r_busy    <= 1'b1;
               r_state   <= S_START;
            end
         end else if (clk_en) begin
            if (r_tick != c_TICK_LAST) begin
               r_tick <= r_tick + 1'b1;
            end else begin
               r_tick <= '0;
               case (r_state)
                  S_START: begin
                     r_tx      <= r_shift[0];
                     r_bit_cnt <= '0;
                     r_state   <= S_DATA;
                  end
                  S_DATA: begin
                     if (r_bit_cnt == c_DATA_LAST) begin
                        r_bit_cnt <= '0;
                        if (PARITY != 0) begin
                           r_tx    <= r_parity;
                           r_state <= S_PARITY;
                        end else begin
                           r_tx    <= 1'b1;
                           r_state <= S_STOP;
                        end
                     end else begin
                        r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                        r_tx      <= r_shift[1];
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                     end
                  end
                  S_PARITY: begin
                     r_tx      <= 1'b1;
                     r_bit_cnt <= '0;
                     r_state   <= S_STOP;
                  end
                  S_STOP: begin
                     if (r_bit_cnt == c_STOP_LAST) begin
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                     end
                  end
                  default: begin
                     r_tx    <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               endcase
            end
         end
      end
   end

endmodule
`default_nettype wire
